// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the wait-state data-memory responder.
//   dmem_state_t   : responder FSM states (IDLE, BUSY, RESP)
//   WORD_W         : data word width
//   DONE_ADDR_DEF  : default byte address whose store ends the program
//   DONE_VALUE_DEF : default value that must be stored there for Pass
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

    localparam int          WORD_W         = 32;
    localparam logic [31:0] DONE_ADDR_DEF  = 32'd100;
    localparam logic [31:0] DONE_VALUE_DEF = 32'd31;

endpackage

// File: rtl/dmem_wait_responder_if.sv
// dmem_wait_responder_if: processor load/store port with a wait-state handshake.
//   MemWrite, MemRead : requests, held by the requester until Ready
//   DataAdr           : byte address, held with the request
//   WriteData         : store data, held with the request
//   ReadData          : load result, valid while Ready is high after a load
//   Ready             : one-cycle completion strobe
// Modports: master (requester side), slave (responder side).
interface dmem_wait_responder_if;
    import dmem_pkg::*;

    logic              MemWrite;
    logic              MemRead;
    logic [31:0]       DataAdr;
    logic [WORD_W-1:0] WriteData;
    logic [WORD_W-1:0] ReadData;
    logic              Ready;

    modport master (
        output MemWrite, MemRead, DataAdr, WriteData,
        input  ReadData, Ready
    );

    modport slave (
        input  MemWrite, MemRead, DataAdr, WriteData,
        output ReadData, Ready
    );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port word array with synchronous write and registered read.
//   clk, reset : clock and synchronous active-high clear of every word and rdata
//   we         : write wdata to word idx on this edge
//   re         : register word idx (or zero when rzero) into rdata on this edge
//   rzero      : the access is out of range; a read returns 0
//   idx        : word index
//   wdata      : write data
//   rdata      : registered read data, held until the next read
module dmem_array import dmem_pkg::*; #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic                     re,
    input  logic                     rzero,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[idx] <= wdata;
            end
            if (re) begin
                rdata <= rzero ? '0 : mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: data-memory responder that inserts WAIT wait states per
// access and raises sticky Done/Pass flags when the program's final store lands.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : slave side of the load/store handshake (see dmem_wait_responder_if)
//   Done       : sticky, the first store to DONE_ADDR has completed
//   Pass       : sticky, that store carried DONE_VALUE
module dmem_wait_responder import dmem_pkg::*; #(
    parameter int                DEPTH      = 64,
    parameter int                WAIT       = 2,
    parameter logic [31:0]       DONE_ADDR  = DONE_ADDR_DEF,
    parameter logic [WORD_W-1:0] DONE_VALUE = DONE_VALUE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_wait_responder_if.slave  bus,
    output logic                  Done,
    output logic                  Pass
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_L = 4'(WAIT);
    localparam logic [31:0] LIMIT  = 32'(4 * DEPTH);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [31:0]       adr_q;
    logic [WORD_W-1:0] data_q;

    logic              req;
    logic              commit;
    logic              c_wr;
    logic [31:0]       c_adr;
    logic [WORD_W-1:0] c_data;
    logic              in_range;

    assign req = bus.MemWrite | bus.MemRead;

    // Commit happens on the edge that enters RESP. With WAIT=0 that is the
    // request edge itself, so the live inputs are used instead of the latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        c_wr    = wr_q;
        c_adr   = adr_q;
        c_data  = data_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    c_wr   = bus.MemWrite;
                    c_adr  = bus.DataAdr;
                    c_data = bus.WriteData;
                    if (WAIT == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        cnt_d   = WAIT_L;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: FSM and wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latches; a simultaneous store and load keeps only the store
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req) begin
            wr_q   <= bus.MemWrite;
            adr_q  <= bus.DataAdr;
            data_q <= bus.WriteData;
        end
    end

    assign in_range = (c_adr < LIMIT);

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (commit & c_wr & in_range),
        .re    (commit & ~c_wr),
        .rzero (~in_range),
        .idx   (c_adr[AW+1:2]),
        .wdata (c_data),
        .rdata (bus.ReadData)
    );

    assign bus.Ready = (state_q == RESP);

    // Completion monitor: only the first completed store to DONE_ADDR decides
    always_ff @(posedge clk) begin
        if (reset) begin
            Done <= 1'b0;
            Pass <= 1'b0;
        end else if (commit && c_wr && c_adr == DONE_ADDR && !Done) begin
            Done <= 1'b1;
            Pass <= (c_data == DONE_VALUE);
        end
    end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb_dmem_wait_responder: bench for dmem_wait_responder. Two instances share a
// clock: dut_a with WAIT=2 and dut_b with WAIT=0. A word-array reference model
// predicts ReadData, latency, and the Done/Pass flags for every access.
module tb_dmem_wait_responder;

    logic clk;
    logic rst_a, rst_b;
    logic done_a, pass_a, done_b, pass_b;

    int total = 0;
    int bad   = 0;

    dmem_wait_responder_if ia();
    dmem_wait_responder_if ib();

    dmem_wait_responder #(.DEPTH(64), .WAIT(2), .DONE_ADDR(32'd100), .DONE_VALUE(32'd31)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ia), .Done(done_a), .Pass(pass_a)
    );

    dmem_wait_responder #(.DEPTH(64), .WAIT(0), .DONE_ADDR(32'd100), .DONE_VALUE(32'd31)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ib), .Done(done_b), .Pass(pass_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state, one set per instance
    logic [31:0] mref  [2][64];
    logic [31:0] rdref [2];
    bit          doneref [2];
    bit          passref [2];
    int          waitv   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_rd(input int sel);
        return (sel == 0) ? ia.ReadData : ib.ReadData;
    endfunction

    function automatic logic obs_rdy(input int sel);
        return (sel == 0) ? ia.Ready : ib.Ready;
    endfunction

    function automatic logic obs_done(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    function automatic logic obs_pass(input int sel);
        return (sel == 0) ? pass_a : pass_b;
    endfunction

    task automatic drive(input int sel, input bit w, input bit r, input logic [31:0] adr, input logic [31:0] d);
        if (sel == 0) begin
            ia.MemWrite = w; ia.MemRead = r; ia.DataAdr = adr; ia.WriteData = d;
        end else begin
            ib.MemWrite = w; ib.MemRead = r; ib.DataAdr = adr; ib.WriteData = d;
        end
    endtask

    task automatic model_clear(input int sel);
        for (int i = 0; i < 64; i++) mref[sel][i] = 32'd0;
        rdref[sel]   = 32'd0;
        doneref[sel] = 1'b0;
        passref[sel] = 1'b0;
    endtask

    // One complete access: issue, wait for Ready (bounded), update model,
    // check latency/ReadData/flags at Ready, then check Ready lasted one cycle.
    task automatic access(input int sel, input bit w, input bit r, input logic [31:0] adr,
                          input logic [31:0] d, input string tag);
        int lat;
        bit got;
        int idx;
        lat = 0;
        got = 1'b0;
        drive(sel, w, r, adr, d);
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            lat++;
            got = obs_rdy(sel);
        end
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        idx = int'((adr / 4) % 64);
        if (w) begin
            if (adr < 32'd256) mref[sel][idx] = d;
            if (adr == 32'd100 && !doneref[sel]) begin
                doneref[sel] = 1'b1;
                passref[sel] = (d == 32'd31);
            end
        end else if (r) begin
            rdref[sel] = (adr < 32'd256) ? mref[sel][idx] : 32'd0;
        end
        chk({tag, ".lat"},  32'(lat), 32'(waitv[sel] + 1));
        chk({tag, ".rd"},   obs_rd(sel), rdref[sel]);
        chk({tag, ".done"}, 32'(obs_done(sel)), 32'(doneref[sel]));
        chk({tag, ".pass"}, 32'(obs_pass(sel)), 32'(passref[sel]));
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'(obs_rdy(sel)), 32'd0);
    endtask

    task automatic do_reset(input int sel);
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        @(posedge clk); #1;
        if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
        model_clear(sel);
    endtask

    task automatic random_run(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] adr;
            logic [31:0] d;
            int op;
            adr = 32'($urandom_range(0, 79) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) adr = 32'd100;
            d  = $urandom;
            if ($urandom_range(0, 3) == 0) d = 32'd31;
            op = int'($urandom_range(0, 2));
            case (op)
                0:       access(sel, 1'b1, 1'b0, adr, d, "rnd.st");
                1:       access(sel, 1'b0, 1'b1, adr, d, "rnd.ld");
                default: access(sel, 1'b1, 1'b1, adr, d, "rnd.both");
            endcase
        end
    endtask

    initial begin
        waitv[0] = 2;
        waitv[1] = 0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        model_clear(0);
        model_clear(1);

        // reset state of both instances
        for (int s = 0; s < 2; s++) begin
            chk("rst.ready", 32'(obs_rdy(s)), 32'd0);
            chk("rst.rd",    obs_rd(s), 32'd0);
            chk("rst.done",  32'(obs_done(s)), 32'd0);
            chk("rst.pass",  32'(obs_pass(s)), 32'd0);
        end

        // WAIT=2: final store of 31 to 100 gives Done/Pass with Ready, readback 31
        access(0, 1'b1, 1'b0, 32'd100, 32'd31, "a.st31");
        chk("a.st31.done_abs", 32'(done_a), 32'd1);
        chk("a.st31.pass_abs", 32'(pass_a), 32'd1);
        access(0, 1'b0, 1'b1, 32'd100, 32'd0, "a.ld100");
        chk("a.ld100.abs", ia.ReadData, 32'd31);

        // first store decides: 7 then 31 leaves Pass=0, memory holds 31
        do_reset(0);
        access(0, 1'b1, 1'b0, 32'd100, 32'd7, "a.st7");
        chk("a.st7.pass_abs", 32'(pass_a), 32'd0);
        access(0, 1'b1, 1'b0, 32'd100, 32'd31, "a.st31b");
        chk("a.st31b.done_abs", 32'(done_a), 32'd1);
        chk("a.st31b.pass_abs", 32'(pass_a), 32'd0);
        access(0, 1'b0, 1'b1, 32'd100, 32'd0, "a.ld100b");
        chk("a.ld100b.abs", ia.ReadData, 32'd31);

        // reset while BUSY aborts the store
        do_reset(0);
        drive(0, 1'b1, 1'b0, 32'd100, 32'd31);
        @(posedge clk); #1;
        rst_a = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        model_clear(0);
        for (int k = 0; k < 4; k++) begin
            chk("mid.ready", 32'(ia.Ready), 32'd0);
            @(posedge clk); #1;
        end
        chk("mid.done", 32'(done_a), 32'd0);
        chk("mid.pass", 32'(pass_a), 32'd0);
        access(0, 1'b0, 1'b1, 32'd100, 32'd0, "mid.ld");
        access(0, 1'b1, 1'b0, 32'd100, 32'd31, "mid.st");
        chk("mid.st.done_abs", 32'(done_a), 32'd1);

        random_run(0, 40);

        // WAIT=0: single-cycle latency, store-then-load
        access(1, 1'b1, 1'b0, 32'd8, 32'hDEADBEEF, "b.st8");
        access(1, 1'b0, 1'b1, 32'd8, 32'd0, "b.ld8");
        chk("b.ld8.abs", ib.ReadData, 32'hDEADBEEF);

        // out of range load returns 0, out of range store changes nothing
        access(1, 1'b0, 1'b1, 32'd256, 32'd0, "b.ld256");
        chk("b.ld256.abs", ib.ReadData, 32'd0);
        access(1, 1'b1, 1'b0, 32'd256, 32'h12345678, "b.st256");
        for (int i = 0; i < 64; i++) begin
            access(1, 1'b0, 1'b1, 32'(i * 4), 32'd0, "b.scan");
        end

        // simultaneous store and load: store wins, ReadData untouched
        access(1, 1'b0, 1'b1, 32'd8, 32'd0, "b.ld8b");
        access(1, 1'b1, 1'b1, 32'd4, 32'd5, "b.both");
        chk("b.both.rd_abs", ib.ReadData, 32'hDEADBEEF);
        access(1, 1'b0, 1'b1, 32'd4, 32'd0, "b.ld4");
        chk("b.ld4.abs", ib.ReadData, 32'd5);

        random_run(1, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
